struct_rec_rx: RTL



---
 rtl/struct_rec_pkg.sv | 28 ++
 rtl/struct_rec_sat_cnt.sv | 20 ++
 rtl/struct_rec_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/struct_rec_pkg.sv
// rtl/struct_rec_pkg.sv - shared types and helpers for the record receiver
package struct_rec_pkg;

  localparam int NBYTES_DEF = 4;

  typedef struct packed {
    logic [7:0] data;
  } rec_field_t;

  typedef rec_field_t rec_t [NBYTES_DEF];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_e;

  // Field k lands in bits [8k+7:8k]; field 0 is the least significant byte.
  function automatic logic [NBYTES_DEF*8-1:0] pack_rec(input rec_t r);
    logic [NBYTES_DEF*8-1:0] v;
    v = '0;
    for (int k = 0; k < NBYTES_DEF; k++) begin
      v[8*k +: 8] = r[k].data;
    end
    return v;
  endfunction

endpackage

// File: rtl/struct_rec_sat_cnt.sv
// rtl/struct_rec_sat_cnt.sv - saturating event counter with increment enable
module struct_rec_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  // Count enabled events, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/struct_rec_rx.sv
// rtl/struct_rec_rx.sv - byte stream to record assembler; STRUCT_REC_RX_PARITY_EN adds per-byte odd parity checking
module struct_rec_rx
  import struct_rec_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_a,
  input  logic                i_a_valid,
`ifdef STRUCT_REC_RX_PARITY_EN
  input  logic                i_a_par,
`endif
  output logic                o_a_ready,
  input  logic                i_flush,
  output logic [NBYTES*8-1:0] o_rec,
  output logic                o_rec_valid,
  input  logic                i_rec_ready,
  output logic                o_rec_err,
  output logic [CNT_W-1:0]    o_drop_cnt
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  rx_state_e         state_q;
  logic [IDX_W-1:0]  idx_q;
  rec_field_t        rec_q [NBYTES];
  logic              a_ready_q;
  logic              rec_valid_q;
  logic              accept;
  logic              drop_inc;

  assign accept = i_a_valid & a_ready_q;

  // A flush only discards something when a record is partly built or held
  // without being taken downstream in the same cycle.
  assign drop_inc = i_flush & ((state_q == COLLECT) |
                               ((state_q == HOLD) & ~i_rec_ready));

  // Record assembly FSM; ready/valid are registered copies of the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_ready_q   <= 1'b0;
      rec_valid_q <= 1'b0;
      for (int k = 0; k < NBYTES; k++) begin
        rec_q[k].data <= 8'h00;
      end
    end else begin
      case (state_q)
        IDLE: begin
          a_ready_q <= 1'b1;
          if (accept && !i_flush) begin
            rec_q[0].data <= i_a;
            if (NBYTES == 1) begin
              idx_q       <= '0;
              state_q     <= HOLD;
              a_ready_q   <= 1'b0;
              rec_valid_q <= 1'b1;
            end else begin
              idx_q   <= IDX_W'(1);
              state_q <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (i_flush) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (accept) begin
            rec_q[idx_q].data <= i_a;
            if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              state_q     <= HOLD;
              a_ready_q   <= 1'b0;
              rec_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (i_rec_ready || i_flush) begin
            state_q     <= IDLE;
            rec_valid_q <= 1'b0;
            a_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          rec_valid_q <= 1'b0;
          a_ready_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef STRUCT_REC_RX_PARITY_EN
  logic err_q;
  logic byte_bad;
  logic to_idle;

  assign byte_bad = ~^{i_a, i_a_par};
  assign to_idle  = i_flush | ((state_q == HOLD) & i_rec_ready);

  // Sticky per-record parity error, restarted whenever a new record begins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      err_q <= accept & ~i_flush & byte_bad;
    end else if (to_idle) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= err_q | byte_bad;
    end
  end

  assign o_rec_err = rec_valid_q & err_q;
`else
  assign o_rec_err = 1'b0;
`endif

  for (genvar k = 0; k < NBYTES; k++) begin : g_pack
    assign o_rec[8*k +: 8] = rec_q[k].data;
  end

  assign o_a_ready   = a_ready_q;
  assign o_rec_valid = rec_valid_q;

  struct_rec_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (drop_inc),
    .o_cnt   (o_drop_cnt)
  );

endmodule
